rf_stream_ctrl: RTL and testbench
=================================

# rf_stream_ctrl

Sequencing master for the register file's read/write port pair: it accepts a load or dump command and then either writes a ready/valid input stream into consecutive register entries, or reads consecutive entries out onto a ready/valid output stream. It sits between the datapath's streaming interfaces and the register file. It drives the file's raddr/waddr/wen/wdata and consumes its combinational rdata. While a command is active it is the only agent driving these signals.

## Interface
- DATAWIDTH, 64, word width; matches the register file.
- RFDEPTH, 4, number of register entries; AW = $clog2(RFDEPTH), CW = AW+1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = load (stream to RF), 1 = dump (RF to stream).
- cmd_base  in  AW  first entry address.
- cmd_count  in  CW  number of entries to transfer.
- in_valid / in_ready  in / out  1  load stream handshake.
- in_data  in  DATAWIDTH  load word.
- out_valid / out_ready  out / in  1  dump stream handshake.
- out_data  out  DATAWIDTH  dump word (registered).
- out_last  out  1  marks the final dump word.
- rf_raddr  out  AW  read address to the register file.
- rf_rdata  in  DATAWIDTH  combinational read data from the register file.
- rf_wen  out  1  write enable to the register file.
- rf_waddr  out  AW  write address.
- rf_wdata  out  DATAWIDTH  write data.
- busy  out  1  high in LOAD, DUMP and DONE.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, LOAD, DUMP, DONE.
- Internal registers: ptr (AW bits) and remaining (CW bits).
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: ptr <= cmd_base and remaining <= min(cmd_count, RFDEPTH). A count above RFDEPTH saturates.
  - Next state is LOAD or DUMP per cmd_op. If the saturated count is 0, the next state is DONE directly.
- LOAD:
  - in_ready = 1.
  - rf_waddr = ptr, rf_wdata = in_data, rf_wen = in_valid (combinational).
  - Each accepted word: ptr <= ptr+1 mod RFDEPTH, remaining <= remaining-1.
  - On acceptance with remaining == 1, go to DONE.
  - in_ready = 0 in all other states.
- DUMP:
  - rf_raddr = ptr.
  - The output register is loaded when (!out_valid || out_ready) && remaining != 0, with:
    - out_data <= rf_rdata
    - out_valid <= 1
    - out_last <= (remaining == 1)
    - ptr and remaining advance as in LOAD.
  - When out_valid && out_ready && out_last: out_valid <= 0, out_last <= 0, go to DONE.
  - out_data is held stable while out_valid && !out_ready.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Address wrap: ptr wraps modulo RFDEPTH. For non-power-of-2 depths, explicit compare to RFDEPTH-1 resets ptr to 0.
- rf_wen = 0 outside LOAD. rf_raddr = ptr in all states. rf_waddr and rf_wdata are don't-care when rf_wen = 0.
- Reset (rst = 0, at any time including mid-operation):
  - State returns to IDLE immediately.
  - Reset values: ptr = 0, remaining = 0, out_valid = 0, out_last = 0, out_data = 0, done = 0, busy = 0, rf_wen = 0.
  - Register file contents are not touched; a partial load stays partially written.

## Timing
- Command accepted at edge E0.
- Load: the first write can occur in the cycle after E0, committing at E1 when in_valid = 1. Sustained rate is 1 word/cycle. in_valid gaps stall without penalty.
- Dump: out_valid = 1 after E1 with entry cmd_base. With out_ready held high, one word per cycle; N words occupy E1..EN.
- Dump backpressure: out_ready = 0 freezes ptr, remaining and out_data. No word is dropped or duplicated.
- DONE occupies the cycle after the last transfer. cmd_ready returns one cycle after done.
- Minimum command-to-command spacing is count + 2 cycles.
- A zero-count command spends one cycle in DONE with no RF or stream activity.
- cmd_valid is ignored while cmd_ready = 0. An in_valid during a dump is ignored (in_ready = 0).

## Test plan
All scenarios use DATAWIDTH=64 and RFDEPTH=4.
- Load base=0, count=4, in_data = 0xA0..0xA3, in_valid always high: rf_wen high 4 consecutive cycles, addresses 0,1,2,3. done pulses once, then cmd_ready = 1.
- Dump base=2, count=4 after the load above, out_ready high: out_data sequence 0xA2, 0xA3, 0xA0, 0xA1 (wrap). out_last only on 0xA1. out_valid first high 1 cycle after cmd accept.
- Dump count=3 with out_ready toggled 1,0,0,1,0,1: exactly 3 words, each held stable while stalled, no duplicates, out_last on the third word.
- Load count=7 (saturates to 4) with in_valid gaps: exactly 4 writes, only on in_valid cycles. A 5th in_valid offered after completion is not accepted (in_ready = 0).
- Command count=0: no rf_wen, no out_valid. done high the cycle after acceptance. busy high for that single cycle.
- Assert rst low mid-dump after 2 words: out_valid, out_last, busy and done drop to 0 immediately. After release, cmd_ready = 1, and a new dump base=0 count=1 returns 0xA0.

Source files
------------

// File: rtl/rf_stream_ctrl.sv
// rf_stream_ctrl: sequencing master for the register file port pair.
// A load command streams in_data words into consecutive entries; a dump
// command reads consecutive entries onto a registered ready/valid stream.
// Addresses wrap modulo RFDEPTH; counts above RFDEPTH saturate.
module rf_stream_ctrl #(
    parameter int DATAWIDTH = 64,
    parameter int RFDEPTH   = 4,
    localparam int AW = (RFDEPTH > 1) ? $clog2(RFDEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,

    // command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [AW-1:0]        cmd_base,
    input  logic [CW-1:0]        cmd_count,

    // load stream (into the register file)
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,

    // dump stream (out of the register file)
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,

    // register file ports
    output logic [AW-1:0]        rf_raddr,
    input  logic [DATAWIDTH-1:0] rf_rdata,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [DATAWIDTH-1:0] rf_wdata,

    // status
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(RFDEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(RFDEPTH - 1);

    state_t         state;
    logic [AW-1:0]  ptr;
    logic [CW-1:0]  remaining;

    logic [CW-1:0]  cnt_sat;
    logic [AW-1:0]  ptr_inc;
    logic           out_load;
    logic           out_fin;

    // Saturate the requested count to the file depth.
    assign cnt_sat = (cmd_count > DEPTH_C) ? DEPTH_C : cmd_count;

    // Explicit wrap compare so non-power-of-2 depths also wrap at RFDEPTH.
    assign ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + AW'(1);

    // Output register may take a new word when empty or being drained,
    // as long as entries are left to read.
    assign out_load = (state == S_DUMP) && (!out_valid || out_ready) &&
                      (remaining != '0);

    // Final word leaves the output register.
    assign out_fin  = (state == S_DUMP) && out_valid && out_ready && out_last;

    // Register-file side: both addresses follow ptr; writes only during LOAD.
    assign rf_raddr = ptr;
    assign rf_waddr = ptr;
    assign rf_wdata = in_data;
    assign rf_wen   = in_ready && in_valid;

    // Main sequencer: state, pointers, dump output register and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            cmd_ready <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ptr       <= cmd_base;
                        remaining <= cnt_sat;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cnt_sat == '0) begin
                            // nothing to move: straight to the done pulse
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cmd_op) begin
                            state <= S_DUMP;
                        end else begin
                            state    <= S_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        ptr       <= ptr_inc;
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end

                S_DUMP: begin
                    if (out_load) begin
                        out_data  <= rf_rdata;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == CW'(1));
                        ptr       <= ptr_inc;
                        remaining <= remaining - CW'(1);
                    end else if (out_fin) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    in_ready  <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_stream_ctrl.sv
// Bench for rf_stream_ctrl: directed test-plan scenarios then random
// load/dump commands, checked against an array model of the file contents
// and an expected-word sequence derived from base/count.
module tb_rf_stream_ctrl;

    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_base;
    logic [CW-1:0] cmd_count;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata;
    logic          rf_wen, busy, done;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rf_mem [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];

    rf_stream_ctrl #(.DATAWIDTH(DW), .RFDEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file: synchronous write, combinational read
    always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_raddr];

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command for one cycle; returns at the negedge after acceptance.
    task automatic issue(input bit op, input int base, input int count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = AW'(base);
        cmd_count = CW'(count);
        #1;
        check("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_load(input int base, input int count, input bit gaps,
                            input bit rnd, input logic [DW-1:0] w0);
        int n;
        int idx;
        int cyc;
        logic [DW-1:0] w;
        n = (count > DEPTH) ? DEPTH : count;
        idx = 0;
        cyc = 0;
        w = rnd ? {$urandom(), $urandom()} : w0;
        issue(1'b0, base, count);
        while (idx < n && cyc < 100) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = w;
            #1;
            check("load_in_ready", in_ready, 1);
            check("load_wen", rf_wen, in_valid);
            if (in_valid) begin
                check("load_waddr", rf_waddr, (base + idx) % DEPTH);
                check("load_wdata", rf_wdata, w);
                exp_mem[(base + idx) % DEPTH] = w;
                idx++;
                w = rnd ? {$urandom(), $urandom()} : w0 + DW'(idx);
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < n) check("load_timeout", idx, n);
        // one more word offered during DONE must not be taken
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF;
        #1;
        check("load_done", done, 1);
        check("load_busy", busy, 1);
        check("load_extra_ready", in_ready, 0);
        check("load_extra_wen", rf_wen, 0);
        check("load_no_out", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("load_done_pulse", done, 0);
        check("load_cmd_ready", cmd_ready, 1);
        check("load_idle_busy", busy, 0);
    endtask

    // mode 0: out_ready always high, 1: random, 2: pattern 1,0,0,1,0,1
    task automatic run_dump(input int base, input int count, input int mode);
        int n;
        int k;
        int cyc;
        bit stalled;
        logic [DW-1:0] hold_d;
        logic [5:0] pat;
        pat = 6'b101001;
        n = (count > DEPTH) ? DEPTH : count;
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        hold_d = '0;
        out_ready = 1'b0;
        issue(1'b1, base, count);
        if (n > 0) begin
            #1;
            check("dump_vld_e0", out_valid, 0);
            check("dump_busy", busy, 1);
            @(negedge clk);
        end
        while (k < n && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) != 0);
                default: out_ready = (cyc < 6) ? pat[cyc] : 1'b1;
            endcase
            #1;
            check("dump_vld", out_valid, 1);
            if (stalled) check("dump_hold", out_data, hold_d);
            if (out_ready) begin
                check("dump_data", out_data, exp_mem[(base + k) % DEPTH]);
                check("dump_last", out_last, (k == n - 1));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < n) check("dump_timeout", k, n);
        out_ready = 1'b1;
        #1;
        check("dump_done", done, 1);
        check("dump_done_busy", busy, 1);
        check("dump_done_vld", out_valid, 0);
        check("dump_no_wen", rf_wen, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("dump_done_pulse", done, 0);
        check("dump_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset state
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_wen", rf_wen, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // directed: full load, wrapping dump, backpressured dump
        run_load(0, 4, 1'b0, 1'b0, 64'hA0);
        run_dump(2, 4, 0);
        run_dump(1, 3, 2);

        // reset in the middle of a dump after two words
        out_ready = 1'b0;
        issue(1'b1, 0, 4);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            out_ready = 1'b1;
            #1;
            check("rstmid_data", out_data, exp_mem[i]);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("rstmid_vld", out_valid, 0);
        check("rstmid_last", out_last, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        check("rstmid_cmd_ready", cmd_ready, 1);
        run_dump(0, 1, 0);

        // saturating load with gaps, then zero-count commands
        run_load(1, 7, 1'b1, 1'b1, 64'h0);
        run_dump(1, 7, 1);
        run_load(3, 0, 1'b0, 1'b1, 64'h0);
        run_dump(2, 0, 0);

        // random commands
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) != 0)
                run_dump($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2));
            else
                run_load($urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 1) != 0), 1'b1, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
